uart_rx_byte: RTL and testbench
===============================

UART_RX_BYTE -- requirements
Module: uart_rx_byte

Interface
REQ-001 Parameter CLKS_PER_BIT, default 10416, SHALL set clk cycles per bit (100 MHz / 9600 baud); legal values are >= 4.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 Port rst, input, 1 bit, SHALL be the asynchronous, active-high reset.
REQ-004 Port Rxd, input, 1 bit, SHALL be the asynchronous serial line: idle high, 8N1 framing, LSB first.
REQ-005 Port data_recv, output, 8 bits, SHALL hold the last byte received with a valid stop bit.
REQ-006 Port Valid, output, 1 bit, SHALL pulse high for one cycle when data_recv updates.
REQ-007 Port Frame_err, output, 1 bit, SHALL pulse high for one cycle when the sampled stop bit is 0.
REQ-008 Port Busy, output, 1 bit, SHALL be high whenever the state is not IDLE.

Function
REQ-009 Rxd SHALL pass through a 2-flop synchronizer (both flops reset to 1); all decisions use the synchronized value rxd_s.
REQ-010 The state machine SHALL have exactly five states: IDLE, START, DATA, STOP, BREAK.
REQ-011 In IDLE, with the bit counter held at 0, rxd_s == 0 SHALL cause a transition to START.
REQ-012 In START, when the counter reaches CLKS_PER_BIT/2 - 1 (integer division), rxd_s SHALL be sampled.
  - Sample 0: go to DATA; clear the counter and the bit index.
  - Sample 1: go to IDLE as a rejected glitch; Valid and Frame_err SHALL NOT assert.
REQ-013 In DATA, on each counter value CLKS_PER_BIT-1:
  - rxd_s SHALL shift into the MSB of an 8-bit shift register (right shift, LSB-first reception).
  - The counter SHALL clear and the bit index SHALL increment.
  - After the 8th sample the machine SHALL go to STOP.
REQ-014 In STOP, rxd_s SHALL be sampled at counter value CLKS_PER_BIT-1.
  - Sample 1: load data_recv from the shift register, assert Valid in the next cycle, go to IDLE.
  - Sample 0: assert Frame_err in the next cycle, leave data_recv unchanged, go to BREAK.
REQ-015 BREAK SHALL remain until rxd_s == 1, then go to IDLE, so a held-low line never produces a spurious frame.
REQ-016 The counter width SHALL be $clog2(CLKS_PER_BIT) bits (14 at the default); the counter SHALL never wrap past CLKS_PER_BIT-1.
REQ-017 Each sample point SHALL fall at bit centre ± 1 cycle, measured from the first cycle rxd_s reads 0.
REQ-018 A start edge arriving in the cycle IDLE is re-entered from STOP SHALL be detected; back-to-back frames need no idle gap.
REQ-019 Valid and Frame_err SHALL be mutually exclusive and never assert for more than one consecutive cycle.

Reset
REQ-020 On rst high, the following SHALL take effect immediately, with no clock required:
  - state = IDLE; counter and bit index = 0.
  - Shift register and data_recv = 8'h00.
  - Valid = Frame_err = Busy = 0; synchronizer flops = 1.
REQ-021 Reset mid-frame SHALL discard the partial byte; the first falling edge after release SHALL start a fresh frame.

Structure
REQ-022 A shared package uart_pkg SHALL hold the state encodings and the default CLKS_PER_BIT; the team's byte transmitter imports the same package.
REQ-023 The synchronizer SHALL be a single sub-module, sync_2ff (parameterized reset value); everything else lives in uart_rx_byte.

Verification (CLKS_PER_BIT=16 unless stated)
REQ-024 Frame 0xA5 at 16 clk/bit -> exactly one Valid pulse, data_recv=0xA5, Frame_err never high, Busy high from start detect to the stop sample.
REQ-025 Rxd low for 3 cycles, then high -> no Valid, no Frame_err; Busy drops within 10 cycles; data_recv unchanged.
REQ-026 Frame 0x3C with stop bit 0, line then held low 64 cycles -> one Frame_err pulse, no Valid, data_recv keeps 0xA5, Busy held through low period, then next frame 0x5A received correctly.
REQ-027 Back-to-back 0x00 then 0xFF, no idle gap -> two Valid pulses with data_recv 0x00 then 0xFF.
REQ-028 rst asserted during data bit 4 -> outputs 0 within the same cycle, without a clock edge; after release, frame 0x81 gives data_recv=0x81.
REQ-029 CLKS_PER_BIT=100, frames 0x55 sent at 97 and at 103 clk/bit -> data_recv=0x55 both times, no Frame_err.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART byte receiver and transmitter.
//   - uart_state_e         : receiver FSM state encoding (also used as a debug view)
//   - CLKS_PER_BIT_DEFAULT : clk cycles per bit, 100 MHz clock at 9600 baud
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 10416;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_rx_byte_if.sv
// uart_rx_byte_if
//   Groups the serial input and the received-byte outputs of uart_rx_byte.
//   Signals:
//     Rxd       : serial line into the receiver (idle high, 8N1, LSB first)
//     data_recv : last byte received with a good stop bit
//     Valid     : one-cycle pulse when data_recv updates
//     Frame_err : one-cycle pulse when the stop bit sampled low
//     Busy      : receiver FSM is not IDLE
//     state     : receiver FSM state, exported for observation
//   Modports:
//     slave  : the receiver (drives the outputs, reads Rxd)
//     master : the line driver / consumer
//   Handshake: there is no backpressure. Valid is a single-cycle strobe and
//   data_recv is stable from that cycle until the next Valid; a consumer
//   must capture it on the Valid cycle or later, before the next frame ends.
interface uart_rx_byte_if;
  import uart_pkg::*;

  logic        Rxd;
  logic [7:0]  data_recv;
  logic        Valid;
  logic        Frame_err;
  logic        Busy;
  uart_state_e state;

  modport slave (
    input  Rxd,
    output data_recv,
    output Valid,
    output Frame_err,
    output Busy,
    output state
  );

  modport master (
    output Rxd,
    input  data_recv,
    input  Valid,
    input  Frame_err,
    input  Busy,
    input  state
  );

endinterface

// File: rtl/sync_2ff.sv
// sync_2ff
//   Two-flop synchronizer for a single asynchronous bit.
//   Ports:
//     clk   : destination clock
//     rst   : asynchronous active-high reset, loads RESET_VAL into both flops
//     d_i   : asynchronous input
//     q_o   : synchronized output (two clk cycles of latency)
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_byte.sv
// uart_rx_byte
//   8N1 UART byte receiver. The serial line is synchronized, a start bit is
//   confirmed at its centre, then eight data bits (LSB first) and the stop
//   bit are sampled at their centres. Good frames update data_recv with a
//   Valid strobe; a low stop bit gives a Frame_err strobe and the receiver
//   waits in BREAK until the line returns high.
//   Parameters:
//     CLKS_PER_BIT : clk cycles per serial bit, >= 4
//   Ports:
//     clk : clock, all state updates on its rising edge
//     rst : asynchronous active-high reset
//     bus : uart_rx_byte_if.slave (Rxd in; data_recv, Valid, Frame_err,
//           Busy, state out)
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_byte_if.slave  bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  // Start bit is checked half a bit after the edge; that realigns every
  // later full-bit count onto the bit centres.
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic rxd_s;

  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [2:0]    idx_q,   idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q,  data_d;
  logic          valid_q, valid_d;
  logic          ferr_q,  ferr_d;

  // Reset to 1 so the idle-high line does not look like a start edge while
  // the synchronizer refills after reset.
  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.Rxd),
    .q_o (rxd_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rxd_s) begin
          state_d = START;
        end
      end

      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          idx_d = '0;
          // A line that is already high again was a glitch, not a start bit.
          state_d = rxd_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      DATA: begin
        if (cnt_q == BIT_LAST) begin
          // LSB arrives first, so shifting right leaves it in bit 0 after 8.
          shift_d = {rxd_s, shift_q[7:1]};
          cnt_d   = '0;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rxd_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      BREAK: begin
        // Hold off until the line goes high so a stuck-low line cannot
        // be mistaken for a stream of start bits.
        cnt_d = '0;
        if (rxd_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  assign bus.data_recv = data_q;
  assign bus.Valid     = valid_q;
  assign bus.Frame_err = ferr_q;
  assign bus.Busy      = (state_q != IDLE);
  assign bus.state     = state_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
module tb_uart_rx_byte;
  import uart_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  uart_rx_byte_if u16 ();
  uart_rx_byte_if u100 ();

  uart_rx_byte #(.CLKS_PER_BIT(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (u16)
  );

  uart_rx_byte #(.CLKS_PER_BIT(100)) dut100 (
    .clk (clk),
    .rst (rst),
    .bus (u100)
  );

  // ---------------- scoreboard ----------------
  // Reference model: a frame whose stop bit is 1 yields its byte; a frame
  // whose stop bit is 0 yields exactly one framing error and no byte.
  logic [7:0] exp_q[$];
  logic [7:0] exp100_q[$];
  logic [7:0] got16_q[$];
  logic [7:0] got100_q[$];
  int exp_ferr16 = 0;
  int ferr16 = 0;
  int ferr100 = 0;
  logic prev_v16 = 1'b0, prev_f16 = 1'b0, prev_v100 = 1'b0, prev_f100 = 1'b0;

  always @(negedge clk) begin
    if (u16.Valid === 1'b1 || u16.Frame_err === 1'b1) begin
      checks++;
      if ((u16.Valid && u16.Frame_err) || (u16.Valid && prev_v16) || (u16.Frame_err && prev_f16)) begin
        errors++;
        $display("FAIL pulse16 valid=%0b ferr=%0b prev_valid=%0b prev_ferr=%0b, want one exclusive single-cycle pulse",
                 u16.Valid, u16.Frame_err, prev_v16, prev_f16);
      end
      if (u16.Valid) got16_q.push_back(u16.data_recv);
      if (u16.Frame_err) ferr16++;
    end
    if (u100.Valid === 1'b1 || u100.Frame_err === 1'b1) begin
      checks++;
      if ((u100.Valid && u100.Frame_err) || (u100.Valid && prev_v100) || (u100.Frame_err && prev_f100)) begin
        errors++;
        $display("FAIL pulse100 valid=%0b ferr=%0b prev_valid=%0b prev_ferr=%0b, want one exclusive single-cycle pulse",
                 u100.Valid, u100.Frame_err, prev_v100, prev_f100);
      end
      if (u100.Valid) got100_q.push_back(u100.data_recv);
      if (u100.Frame_err) ferr100++;
    end
    prev_v16  <= u16.Valid;
    prev_f16  <= u16.Frame_err;
    prev_v100 <= u100.Valid;
    prev_f100 <= u100.Frame_err;
  end

  // ---------------- driver tasks ----------------
  task automatic send_frame(input bit sel100, input logic [7:0] b, input logic stop,
                            input int period, input bit chk_busy);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    if (sel100) begin
      if (stop) exp100_q.push_back(b);
    end else begin
      if (stop) exp_q.push_back(b);
      else exp_ferr16++;
    end
    for (int i = 0; i < 10; i++) begin
      if (sel100) u100.Rxd = f[i];
      else u16.Rxd = f[i];
      for (int c = 0; c < period; c++) begin
        @(negedge clk);
        if (chk_busy && i >= 1 && i <= 8 && c == period / 2) begin
          checks++;
          if (u16.Busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_in_frame bit=%0d got=%b want=1", i, u16.Busy);
          end
        end
      end
    end
  endtask

  task automatic idle(input bit sel100, input int n);
    if (sel100) u100.Rxd = 1'b1;
    else u16.Rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    u16.Rxd = 1'b1;
    u100.Rxd = 1'b1;
    #1 rst = 1'b1;
    #1;
    checks += 6;
    if (u16.state !== IDLE) begin errors++; $display("FAIL rst_state got=%0d want=%0d", u16.state, IDLE); end
    if (u16.Busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b want=0", u16.Busy); end
    if (u16.Valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b want=0", u16.Valid); end
    if (u16.Frame_err !== 1'b0) begin errors++; $display("FAIL rst_ferr got=%b want=0", u16.Frame_err); end
    if (u16.data_recv !== 8'h00) begin errors++; $display("FAIL rst_data got=%h want=00", u16.data_recv); end
    if (u100.data_recv !== 8'h00) begin errors++; $display("FAIL rst_data100 got=%h want=00", u100.data_recv); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (u16.Busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy cyc=%0d got=%b want=0", i, u16.Busy); end
    end
    idle(0, 4);
  endtask

  task automatic test_basic();
    send_frame(0, 8'hA5, 1'b1, 16, 1);
    idle(0, 20);
    checks += 4;
    if (u16.Busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got=%b want=0", u16.Busy); end
    if (ferr16 !== exp_ferr16) begin errors++; $display("FAIL basic_ferr got=%0d want=%0d", ferr16, exp_ferr16); end
    if (u16.data_recv !== 8'hA5) begin errors++; $display("FAIL basic_data got=%h want=a5", u16.data_recv); end
    if (got16_q.size() != exp_q.size()) begin
      errors++; $display("FAIL basic_count got=%0d want=%0d", got16_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got16_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_byte idx=%0d got=%h want=%h", i, got16_q[i], exp_q[i]); end
      end
    end
    got16_q.delete();
    exp_q.delete();
  endtask

  task automatic test_glitch();
    u16.Rxd = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (u16.Busy !== 1'b1) begin errors++; $display("FAIL glitch_start_busy got=%b want=1", u16.Busy); end
    u16.Rxd = 1'b1;
    repeat (10) @(negedge clk);
    checks += 4;
    if (u16.Busy !== 1'b0) begin errors++; $display("FAIL glitch_busy got=%b want=0", u16.Busy); end
    if (got16_q.size() != 0) begin errors++; $display("FAIL glitch_valid got=%0d want=0", got16_q.size()); end
    if (ferr16 !== exp_ferr16) begin errors++; $display("FAIL glitch_ferr got=%0d want=%0d", ferr16, exp_ferr16); end
    if (u16.data_recv !== 8'hA5) begin errors++; $display("FAIL glitch_data got=%h want=a5", u16.data_recv); end
    idle(0, 5);
  endtask

  task automatic test_frame_err();
    send_frame(0, 8'h3C, 1'b0, 16, 1);
    u16.Rxd = 1'b0;
    repeat (64) @(negedge clk);
    checks += 4;
    if (u16.Busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_low got=%b want=1", u16.Busy); end
    if (ferr16 !== exp_ferr16) begin errors++; $display("FAIL ferr_count got=%0d want=%0d", ferr16, exp_ferr16); end
    if (got16_q.size() != 0) begin errors++; $display("FAIL ferr_valid got=%0d want=0", got16_q.size()); end
    if (u16.data_recv !== 8'hA5) begin errors++; $display("FAIL ferr_data got=%h want=a5", u16.data_recv); end
    idle(0, 20);
    checks++;
    if (u16.Busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_release got=%b want=0", u16.Busy); end
    send_frame(0, 8'h5A, 1'b1, 16, 0);
    idle(0, 20);
    checks += 2;
    if (u16.data_recv !== 8'h5A) begin errors++; $display("FAIL ferr_next_data got=%h want=5a", u16.data_recv); end
    if (got16_q.size() != exp_q.size()) begin
      errors++; $display("FAIL ferr_next_count got=%0d want=%0d", got16_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got16_q[i] !== exp_q[i]) begin errors++; $display("FAIL ferr_next_byte idx=%0d got=%h want=%h", i, got16_q[i], exp_q[i]); end
      end
    end
    got16_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    send_frame(0, 8'h00, 1'b1, 16, 0);
    send_frame(0, 8'hFF, 1'b1, 16, 0);
    idle(0, 20);
    checks += 2;
    if (ferr16 !== exp_ferr16) begin errors++; $display("FAIL b2b_ferr got=%0d want=%0d", ferr16, exp_ferr16); end
    if (got16_q.size() != exp_q.size()) begin
      errors++; $display("FAIL b2b_count got=%0d want=%0d", got16_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got16_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_byte idx=%0d got=%h want=%h", i, got16_q[i], exp_q[i]); end
      end
    end
    got16_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_midframe();
    logic [9:0] f;
    f = {1'b1, 8'h6B, 1'b0};
    for (int i = 0; i < 5; i++) begin
      u16.Rxd = f[i];
      repeat (16) @(negedge clk);
    end
    u16.Rxd = f[5];
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks += 5;
    if (u16.Busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got=%b want=0", u16.Busy); end
    if (u16.Valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got=%b want=0", u16.Valid); end
    if (u16.Frame_err !== 1'b0) begin errors++; $display("FAIL mid_rst_ferr got=%b want=0", u16.Frame_err); end
    if (u16.data_recv !== 8'h00) begin errors++; $display("FAIL mid_rst_data got=%h want=00", u16.data_recv); end
    if (u16.state !== IDLE) begin errors++; $display("FAIL mid_rst_state got=%0d want=%0d", u16.state, IDLE); end
    @(negedge clk);
    u16.Rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(0, 20);
    checks += 2;
    if (got16_q.size() != 0) begin errors++; $display("FAIL mid_partial_valid got=%0d want=0", got16_q.size()); end
    if (ferr16 !== exp_ferr16) begin errors++; $display("FAIL mid_partial_ferr got=%0d want=%0d", ferr16, exp_ferr16); end
    send_frame(0, 8'h81, 1'b1, 16, 1);
    idle(0, 20);
    checks += 2;
    if (u16.data_recv !== 8'h81) begin errors++; $display("FAIL mid_next_data got=%h want=81", u16.data_recv); end
    if (got16_q.size() != exp_q.size()) begin
      errors++; $display("FAIL mid_next_count got=%0d want=%0d", got16_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got16_q[i] !== exp_q[i]) begin errors++; $display("FAIL mid_next_byte idx=%0d got=%h want=%h", i, got16_q[i], exp_q[i]); end
      end
    end
    got16_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic       stop;
    logic [7:0] last_good;
    last_good = 8'h81;
    for (int n = 0; n < 10; n++) begin
      b = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      send_frame(0, b, stop, 16, 0);
      if (stop) begin
        last_good = b;
        idle(0, $urandom_range(0, 12));
      end else begin
        repeat ($urandom_range(0, 20)) @(negedge clk);
        idle(0, $urandom_range(3, 12));
      end
    end
    idle(0, 20);
    checks += 3;
    if (ferr16 !== exp_ferr16) begin errors++; $display("FAIL rand_ferr got=%0d want=%0d", ferr16, exp_ferr16); end
    if (u16.data_recv !== last_good) begin errors++; $display("FAIL rand_data got=%h want=%h", u16.data_recv, last_good); end
    if (u16.Busy !== 1'b0) begin errors++; $display("FAIL rand_busy got=%b want=0", u16.Busy); end
    checks++;
    if (got16_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_count got=%0d want=%0d", got16_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got16_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_byte idx=%0d got=%h want=%h", i, got16_q[i], exp_q[i]); end
      end
    end
    got16_q.delete();
    exp_q.delete();
  endtask

  task automatic test_baud_tolerance();
    int periods[2];
    periods[0] = 97;
    periods[1] = 103;
    for (int k = 0; k < 2; k++) begin
      send_frame(1, 8'h55, 1'b1, periods[k], 0);
      idle(1, 60);
      checks += 3;
      if (u100.data_recv !== 8'h55) begin errors++; $display("FAIL baud%0d_data got=%h want=55", periods[k], u100.data_recv); end
      if (ferr100 !== 0) begin errors++; $display("FAIL baud%0d_ferr got=%0d want=0", periods[k], ferr100); end
      if (got100_q.size() != exp100_q.size()) begin
        errors++; $display("FAIL baud%0d_count got=%0d want=%0d", periods[k], got100_q.size(), exp100_q.size());
      end else begin
        for (int i = 0; i < exp100_q.size(); i++) begin
          checks++;
          if (got100_q[i] !== exp100_q[i]) begin errors++; $display("FAIL baud%0d_byte got=%h want=%h", periods[k], got100_q[i], exp100_q[i]); end
        end
      end
      got100_q.delete();
      exp100_q.delete();
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    test_baud_tolerance();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
